// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: RISC-V funct3 codes, data_mem
// write_en codes, FSM state encoding and request legality helpers.
package lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] WE_SW = 2'b00;
  localparam logic [1:0] WE_SH = 2'b01;
  localparam logic [1:0] WE_SB = 2'b10;
  localparam logic [1:0] WE_RD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_ISSUE     = 2'd1,
    S_LOAD_WAIT = 2'd2,
    S_RESP      = 2'd3
  } lsu_state_e;

  function automatic logic f3_legal(input logic is_store, input logic [2:0] f3);
    logic common;
    common = (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
    if (is_store) return common;
    return common || (f3 == F3_BU) || (f3 == F3_HU);
  endfunction

  function automatic logic [1:0] store_we(input logic [2:0] f3);
    case (f3)
      F3_B:    return WE_SB;
      F3_H:    return WE_SH;
      default: return WE_SW;
    endcase
  endfunction

endpackage

// File: rtl/lsu_load_ext.sv
// Combinational load formatter: picks byte/halfword/word from the raw
// data_mem word and sign- or zero-extends it according to funct3.
module lsu_load_ext
  import lsu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      i_funct3,
  input  logic [XLEN-1:0] i_raw,
  output logic [XLEN-1:0] o_data
);

  always_comb begin
    o_data = i_raw;
    case (i_funct3)
      F3_B:    o_data = {{(XLEN-8){i_raw[7]}}, i_raw[7:0]};
      F3_BU:   o_data = {{(XLEN-8){1'b0}}, i_raw[7:0]};
      F3_H:    o_data = {{(XLEN-16){i_raw[15]}}, i_raw[15:0]};
      F3_HU:   o_data = {{(XLEN-16){1'b0}}, i_raw[15:0]};
      default: o_data = i_raw;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit between the execute/memory stage and data_mem.
// Optional `MISALIGN_TRAP_EN turns misaligned halfword/word accesses into errors.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int XLEN   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              resp_valid,
  output logic [XLEN-1:0]   resp_rdata,
  output logic              resp_err,
  output logic [1:0]        mem_write_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [XLEN-1:0]   mem_data_in,
  input  logic [XLEN-1:0]   mem_data_out
);

  lsu_state_e      r_state;
  logic            r_is_store;
  logic            r_err;
  logic [2:0]      r_funct3;
  logic            w_misalign;
  logic            w_req_err;
  logic [XLEN-1:0] w_ext;

`ifdef MISALIGN_TRAP_EN
  assign w_misalign = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                      ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  assign w_req_err = !f3_legal(req_is_store, req_funct3) || w_misalign;

  lsu_load_ext #(.XLEN(XLEN)) u_load_ext (
    .i_funct3 (r_funct3),
    .i_raw    (mem_data_out),
    .o_data   (w_ext)
  );

  // mem_write_en is loaded on the accept edge so that the write code is
  // present for exactly the ISSUE cycle and is WE_RD everywhere else.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_is_store   <= 1'b0;
      r_err        <= 1'b0;
      r_funct3     <= '0;
      req_ready    <= 1'b1;
      resp_valid   <= 1'b0;
      resp_rdata   <= '0;
      resp_err     <= 1'b0;
      mem_write_en <= WE_RD;
      mem_addr     <= '0;
      mem_data_in  <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (req_valid) begin
            r_is_store   <= req_is_store;
            r_funct3     <= req_funct3;
            r_err        <= w_req_err;
            mem_addr     <= req_addr;
            mem_data_in  <= req_wdata;
            mem_write_en <= (req_is_store && !w_req_err) ? store_we(req_funct3) : WE_RD;
            req_ready    <= 1'b0;
            r_state      <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          mem_write_en <= WE_RD;
          if (r_err || r_is_store) begin
            resp_valid <= 1'b1;
            resp_rdata <= '0;
            resp_err   <= r_err;
            r_state    <= S_RESP;
          end else begin
            r_state <= S_LOAD_WAIT;
          end
        end
        S_LOAD_WAIT: begin
          resp_valid <= 1'b1;
          resp_rdata <= w_ext;
          resp_err   <= 1'b0;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          req_ready <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit with a byte-addressed data_mem
// stand-in (4 KiB, wrapping) and a response scoreboard.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_is_store = 1'b0;
  logic [2:0]  req_funct3 = 3'b000;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [1:0]  mem_write_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_data_in;
  logic [31:0] mem_data_out;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          cyc;
    string       tag;
  } exp_t;

  exp_t        sbQ[$];
  int          nCompared = 0;
  int          nMismatched = 0;
  int          cyc = 0;
  int          writeCount = 0;
  logic [31:0] lastWriteAddr = '0;
  logic [1:0]  lastWriteWe = 2'b11;
  logic [7:0]  memArr [0:4095];
  logic [7:0]  refMem [0:4095];
  logic        memInit = 1'b0;
  logic [11:0] ma0, ma1, ma2, ma3;

  load_store_unit #(.ADDR_W(32), .XLEN(32)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_is_store (req_is_store),
    .req_funct3   (req_funct3),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_err     (resp_err),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  assign ma0 = mem_addr[11:0];
  assign ma1 = ma0 + 12'd1;
  assign ma2 = ma0 + 12'd2;
  assign ma3 = ma0 + 12'd3;

  // data_mem stand-in: registered read, lane alignment done here from the byte address
  always @(posedge clk) begin
    if (!memInit) begin
      for (int i = 0; i < 4096; i++) memArr[i] <= 8'(i) ^ 8'h5A;
      memInit <= 1'b1;
    end else begin
      case (mem_write_en)
        2'b10: memArr[ma0] <= mem_data_in[7:0];
        2'b01: begin
          memArr[ma0] <= mem_data_in[7:0];
          memArr[ma1] <= mem_data_in[15:8];
        end
        2'b00: begin
          memArr[ma0] <= mem_data_in[7:0];
          memArr[ma1] <= mem_data_in[15:8];
          memArr[ma2] <= mem_data_in[23:16];
          memArr[ma3] <= mem_data_in[31:24];
        end
        default: mem_data_out <= {memArr[ma3], memArr[ma2], memArr[ma1], memArr[ma0]};
      endcase
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    nCompared++;
    if (actual !== expected) begin
      nMismatched++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && mem_write_en !== 2'b11) begin
      writeCount++;
      lastWriteAddr = mem_addr;
      lastWriteWe   = mem_write_en;
    end
    if (rst_n && resp_valid) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpected_resp", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sbQ.pop_front();
        checkOutput({e.tag, "_rdata"}, resp_rdata, e.rdata);
        checkOutput({e.tag, "_err"}, 32'(resp_err), 32'(e.err));
        checkOutput({e.tag, "_latency"}, 32'(cyc), 32'(e.cyc));
      end
    end
  end

  function automatic logic tbLegal(input logic isStore, input logic [2:0] f3, input logic [31:0] a);
    logic ok;
    if (isStore) ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010);
    else         ok = (f3 == 3'b000) || (f3 == 3'b001) || (f3 == 3'b010) ||
                      (f3 == 3'b100) || (f3 == 3'b101);
`ifdef MISALIGN_TRAP_EN
    if ((f3 == 3'b001 || f3 == 3'b101) && a[0]) ok = 1'b0;
    if (f3 == 3'b010 && a[1:0] != 2'b00) ok = 1'b0;
`endif
    return ok;
  endfunction

  function automatic logic [31:0] refLoad(input logic [2:0] f3, input logic [31:0] a);
    logic [11:0] b;
    logic [31:0] raw;
    b   = a[11:0];
    raw = {refMem[b + 12'd3], refMem[b + 12'd2], refMem[b + 12'd1], refMem[b]};
    case (f3)
      3'b000:  return {{24{raw[7]}}, raw[7:0]};
      3'b100:  return {24'h0, raw[7:0]};
      3'b001:  return {{16{raw[15]}}, raw[15:0]};
      3'b101:  return {16'h0, raw[15:0]};
      default: return raw;
    endcase
  endfunction

  task automatic applyStimulus(input logic isStore, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd, input string tag);
    int   n = 0;
    exp_t e;
    logic ok;
    @(negedge clk);
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) checkOutput({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    req_valid    = 1'b1;
    req_is_store = isStore;
    req_funct3   = f3;
    req_addr     = a;
    req_wdata    = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hXXXX_XXXX;
    req_wdata = 32'hXXXX_XXXX;
    ok    = tbLegal(isStore, f3, a);
    e.tag = tag;
    e.err = !ok;
    if (!ok || isStore) begin
      e.rdata = 32'h0;
      e.cyc   = cyc + 1;
      if (ok) begin
        for (int k = 0; k < ((f3 == 3'b000) ? 1 : (f3 == 3'b001) ? 2 : 4); k++)
          refMem[a[11:0] + 12'(k)] = wd[8*k +: 8];
      end
    end else begin
      e.rdata = refLoad(f3, a);
      e.cyc   = cyc + 2;
    end
    sbQ.push_back(e);
  endtask

  task automatic waitIdle(input string tag);
    int n = 0;
    while ((sbQ.size() != 0 || !req_ready) && n < 30) begin
      @(negedge clk);
      n++;
    end
    if (n >= 30) checkOutput({tag, "_idle_timeout"}, 32'd0, 32'd1);
  endtask

  initial begin
    int wc;
    for (int i = 0; i < 4096; i++) refMem[i] = 8'(i) ^ 8'h5A;

    repeat (3) @(negedge clk);
    checkOutput("reset_we", 32'(mem_write_en), 32'd3);
    checkOutput("reset_ready", 32'(req_ready), 32'd1);
    checkOutput("reset_resp_valid", 32'(resp_valid), 32'd0);
    checkOutput("reset_rdata", resp_rdata, 32'd0);
    checkOutput("reset_mem_addr", mem_addr, 32'd0);
    rst_n = 1'b1;

    wc = writeCount;
    applyStimulus(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF, "sw_100");
    waitIdle("sw_100");
    checkOutput("sw_100_write_count", 32'(writeCount - wc), 32'd1);
    checkOutput("sw_100_write_addr", lastWriteAddr, 32'h0000_0100);
    checkOutput("sw_100_write_code", 32'(lastWriteWe), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0100, 32'h0, "lw_100");

    applyStimulus(1'b1, 3'b000, 32'h0000_0203, 32'h0000_0080, "sb_203");
    waitIdle("sb_203");
    checkOutput("sb_203_write_code", 32'(lastWriteWe), 32'd2);
    applyStimulus(1'b0, 3'b000, 32'h0000_0203, 32'h0, "lb_203");
    applyStimulus(1'b0, 3'b100, 32'h0000_0203, 32'h0, "lbu_203");

    applyStimulus(1'b1, 3'b001, 32'h0000_03FF, 32'h0000_BEEF, "sh_3ff");
    applyStimulus(1'b0, 3'b001, 32'h0000_03FF, 32'h0, "lh_3ff");
    applyStimulus(1'b0, 3'b101, 32'h0000_03FF, 32'h0, "lhu_3ff");
    applyStimulus(1'b0, 3'b100, 32'h0000_03FF, 32'h0, "lbu_3ff");
    applyStimulus(1'b0, 3'b010, 32'h0000_03FC, 32'h0, "lw_3fc");

    waitIdle("pre_illegal");
    wc = writeCount;
    applyStimulus(1'b1, 3'b011, 32'h0000_0040, 32'hCAFE_F00D, "st_illegal");
    waitIdle("st_illegal");
    checkOutput("st_illegal_write_count", 32'(writeCount - wc), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0040, 32'h0, "lw_40");
    applyStimulus(1'b0, 3'b111, 32'h0000_0044, 32'h0, "ld_illegal");
    applyStimulus(1'b0, 3'b010, 32'h0000_1100, 32'h0, "lw_wrap");

    waitIdle("pre_rst");
    wc = writeCount;
    @(negedge clk);
    req_valid    = 1'b1;
    req_is_store = 1'b1;
    req_funct3   = 3'b010;
    req_addr     = 32'h0000_0080;
    req_wdata    = 32'h1234_5678;
    @(posedge clk);
    #2;
    req_valid = 1'b0;
    rst_n     = 1'b0;
    #1;
    checkOutput("midrst_we", 32'(mem_write_en), 32'd3);
    checkOutput("midrst_ready", 32'(req_ready), 32'd1);
    checkOutput("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    checkOutput("midrst_write_count", 32'(writeCount - wc), 32'd0);
    applyStimulus(1'b0, 3'b010, 32'h0000_0080, 32'h0, "lw_80_after_rst");

    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = $urandom;
      applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a, $urandom, $sformatf("rnd%0d", i));
    end

    waitIdle("final");
    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: got 0x00000000 expected 0x00000001");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
